// File: rtl/spi_ram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// spi_shared : types shared by the SPI/host RAM arbiter slice.
//
// Contents:
//   PEND_ADDR_WIDTH / PEND_DATA_WIDTH : widths of the pending-access record
//   spi_cmd_e    : 2-bit SPI command field carried in rx_data[9:8]
//   arb_state_e  : arbiter FSM states
//   requester_e  : identifies the SPI path or the host port
//   pend_req_t   : one buffered SPI access {we, addr, data}
// ---------------------------------------------------------------------------
package spi_shared;

    localparam int PEND_ADDR_WIDTH = 8;
    localparam int PEND_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } spi_cmd_e;

    typedef enum logic {
        ARB_IDLE,
        ARB_RD_WAIT
    } arb_state_e;

    typedef enum logic {
        REQ_SPI,
        REQ_HOST
    } requester_e;

    typedef struct packed {
        logic                       we;
        logic [PEND_ADDR_WIDTH-1:0] addr;
        logic [PEND_DATA_WIDTH-1:0] data;
    } pend_req_t;

endpackage

// File: rtl/spi_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// spi_ram_arbiter_if : bundles the SPI slave, host port and RAM signals that
// surround the arbiter.
//
// Modports:
//   slave  : arbiter view (consumes SPI rx, host requests, RAM read data;
//            drives SPI tx, host responses and the RAM control bus)
//   master : surrounding-system view (the opposite directions)
// ---------------------------------------------------------------------------
interface spi_ram_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);

    // SPI slave side
    logic [DATA_WIDTH+1:0] spi_rx_data;
    logic                  spi_rx_valid;
    logic [DATA_WIDTH-1:0] spi_tx_data;
    logic                  spi_tx_valid;
    logic                  spi_overrun;

    // Host port
    logic                  host_req;
    logic                  host_we;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic [DATA_WIDTH-1:0] host_wdata;
    logic                  host_gnt;
    logic [DATA_WIDTH-1:0] host_rdata;
    logic                  host_rvalid;

    // Single-port RAM
    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport slave (
        input  spi_rx_data, spi_rx_valid,
        input  host_req, host_we, host_addr, host_wdata,
        input  ram_rdata,
        output spi_tx_data, spi_tx_valid, spi_overrun,
        output host_gnt, host_rdata, host_rvalid,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output spi_rx_data, spi_rx_valid,
        output host_req, host_we, host_addr, host_wdata,
        output ram_rdata,
        input  spi_tx_data, spi_tx_valid, spi_overrun,
        input  host_gnt, host_rdata, host_rvalid,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/spi_ram_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2 : two-requester round-robin arbiter (SPI vs host).
//
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   en                 : grants are only issued while en is high
//   req_spi, req_host  : request lines
//   gnt_spi, gnt_host  : one-hot combinational grants
//
// last_gnt resets to HOST so that SPI wins the first tie after reset.
// ---------------------------------------------------------------------------
module rr_arb2
    import spi_shared::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_spi,
    input  logic req_host,
    output logic gnt_spi,
    output logic gnt_host
);

    requester_e last_gnt;

    // On a tie the requester that did not win last time is granted;
    // a lone requester is always granted.
    always_comb begin
        gnt_spi  = 1'b0;
        gnt_host = 1'b0;
        if (en) begin
            if (req_spi && req_host) begin
                if (last_gnt == REQ_HOST) begin
                    gnt_spi = 1'b1;
                end else begin
                    gnt_host = 1'b1;
                end
            end else begin
                gnt_spi  = req_spi;
                gnt_host = req_host;
            end
        end
    end

    // Remember the most recent winner for the next tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= REQ_HOST;
        end else if (gnt_spi) begin
            last_gnt <= REQ_SPI;
        end else if (gnt_host) begin
            last_gnt <= REQ_HOST;
        end
    end

endmodule

// File: rtl/spi_ram_arbiter.sv
// ---------------------------------------------------------------------------
// spi_ram_arbiter : shares one single-port RAM (1-cycle read latency) between
// the SPI slave receive path and a local host port.
//
// Ports:
//   clk  : clock, all logic on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : spi_ram_arbiter_if.slave
//          spi_rx_data/valid  -> 10-bit command words {cmd, payload}
//          spi_tx_data/valid  <- SPI read data strobe
//          spi_overrun        <- pulse when an SPI access is dropped
//          host_req/we/addr/wdata -> host request, held until host_gnt
//          host_gnt           <- combinational grant (access this cycle)
//          host_rdata/rvalid  <- host read data strobe
//          ram_en/we/addr/wdata, ram_rdata : RAM port
//
// SPI write/read data commands are buffered in a one-deep pending slot that
// carries its own address, so later address commands never disturb it.
// ---------------------------------------------------------------------------
module spi_ram_arbiter
    import spi_shared::*;
#(
    parameter int ADDR_WIDTH = PEND_ADDR_WIDTH,
    parameter int DATA_WIDTH = PEND_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    spi_ram_arbiter_if.slave bus
);

    arb_state_e state, state_next;
    requester_e owner, owner_next;

    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    pend_req_t             slot;
    logic                  slot_valid;

    spi_cmd_e              cmd;
    logic [DATA_WIDTH-1:0] payload;

    logic gnt_spi;
    logic gnt_host;

    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;

    logic [DATA_WIDTH-1:0] spi_tx_data;
    logic                  spi_tx_valid;
    logic                  spi_overrun;
    logic [DATA_WIDTH-1:0] host_rdata;
    logic                  host_rvalid;

    assign cmd     = spi_cmd_e'(bus.spi_rx_data[DATA_WIDTH+1:DATA_WIDTH]);
    assign payload = bus.spi_rx_data[DATA_WIDTH-1:0];

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .en       (state == ARB_IDLE),
        .req_spi  (slot_valid),
        .req_host (bus.host_req),
        .gnt_spi  (gnt_spi),
        .gnt_host (gnt_host)
    );

    // FSM state and the owner of an in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
            owner <= REQ_SPI;
        end else begin
            state <= state_next;
            owner <= owner_next;
        end
    end

    // Next state and RAM drive. The granted requester drives the RAM in the
    // grant cycle; a read then parks in RD_WAIT for the RAM latency cycle.
    always_comb begin
        state_next = state;
        owner_next = owner;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        unique case (state)
            ARB_IDLE: begin
                if (gnt_spi) begin
                    ram_en    = 1'b1;
                    ram_we    = slot.we;
                    ram_addr  = slot.addr;
                    ram_wdata = slot.we ? slot.data : '0;
                    if (!slot.we) begin
                        state_next = ARB_RD_WAIT;
                        owner_next = REQ_SPI;
                    end
                end else if (gnt_host) begin
                    ram_en    = 1'b1;
                    ram_we    = bus.host_we;
                    ram_addr  = bus.host_addr;
                    ram_wdata = bus.host_we ? bus.host_wdata : '0;
                    if (!bus.host_we) begin
                        state_next = ARB_RD_WAIT;
                        owner_next = REQ_HOST;
                    end
                end
            end
            ARB_RD_WAIT: begin
                state_next = ARB_IDLE;
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // Command decode and the pending slot. A slot granted this cycle frees up
    // in time to accept a same-cycle data command; otherwise a data command
    // hitting a full slot is dropped and flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr     <= '0;
            rd_addr     <= '0;
            slot        <= '0;
            slot_valid  <= 1'b0;
            spi_overrun <= 1'b0;
        end else begin
            spi_overrun <= 1'b0;
            if (gnt_spi) begin
                slot_valid <= 1'b0;
            end
            if (bus.spi_rx_valid) begin
                unique case (cmd)
                    CMD_WR_ADDR: wr_addr <= ADDR_WIDTH'(payload);
                    CMD_RD_ADDR: rd_addr <= ADDR_WIDTH'(payload);
                    CMD_WR_DATA, CMD_RD_DATA: begin
                        if (!slot_valid || gnt_spi) begin
                            slot_valid <= 1'b1;
                            if (cmd == CMD_WR_DATA) begin
                                slot <= '{we: 1'b1, addr: wr_addr, data: payload};
                            end else begin
                                slot <= '{we: 1'b0, addr: rd_addr, data: '0};
                            end
                        end else begin
                            spi_overrun <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read-data return: in RD_WAIT the RAM output is valid and is steered to
    // whichever requester launched the read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_tx_data  <= '0;
            spi_tx_valid <= 1'b0;
            host_rdata   <= '0;
            host_rvalid  <= 1'b0;
        end else begin
            spi_tx_valid <= 1'b0;
            host_rvalid  <= 1'b0;
            if (state == ARB_RD_WAIT) begin
                if (owner == REQ_SPI) begin
                    spi_tx_data  <= bus.ram_rdata;
                    spi_tx_valid <= 1'b1;
                end else begin
                    host_rdata  <= bus.ram_rdata;
                    host_rvalid <= 1'b1;
                end
            end
        end
    end

    assign bus.ram_en       = ram_en;
    assign bus.ram_we       = ram_we;
    assign bus.ram_addr     = ram_addr;
    assign bus.ram_wdata    = ram_wdata;
    assign bus.host_gnt     = gnt_host;
    assign bus.host_rdata   = host_rdata;
    assign bus.host_rvalid  = host_rvalid;
    assign bus.spi_tx_data  = spi_tx_data;
    assign bus.spi_tx_valid = spi_tx_valid;
    assign bus.spi_overrun  = spi_overrun;

endmodule

// File: doc/spi_ram_arbiter.md
# spi_ram_arbiter

Controller that shares one single-port RAM between the SPI slave's receive path and a local host port. Decodes the 10-bit SPI command words (write-address, write-data, read-address, read-data), holds one pending SPI access, arbitrates it round-robin against host requests, and routes RAM read data back to the SPI transmit path or to the host. Sits in the SPI wrapper between the SPI slave and the RAM.

## Interface
- `ADDR_WIDTH`, 8: RAM address width.
- `DATA_WIDTH`, 8: RAM data width; SPI payload width (rx_data = {cmd[1:0], payload}).
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `spi_rx_data` in DATA_WIDTH+2: SPI command word; [9:8] is the command, [7:0] is the payload.
- `spi_rx_valid` in 1: one-cycle strobe; `spi_rx_data` is valid in that cycle.
- `spi_tx_data` out DATA_WIDTH: read data returned to the SPI slave.
- `spi_tx_valid` out 1: one-cycle strobe for `spi_tx_data`.
- `spi_overrun` out 1: one-cycle pulse when an SPI access is dropped.
- `host_req` in 1: host request; held high until granted.
- `host_we` in 1: 1 = write, 0 = read.
- `host_addr` in ADDR_WIDTH: host address.
- `host_wdata` in DATA_WIDTH: host write data.
- `host_gnt` out 1: combinational grant; the access happens in this cycle.
- `host_rdata` out DATA_WIDTH: host read data.
- `host_rvalid` out 1: one-cycle strobe for `host_rdata`.
- `ram_en` out 1: RAM enable.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out ADDR_WIDTH: RAM address.
- `ram_wdata` out DATA_WIDTH: RAM write data.
- `ram_rdata` in DATA_WIDTH: RAM read data; fixed 1-cycle read latency.

## Operation
- Command decode on `spi_rx_valid`:
  - 00 (WR_ADDR): latch `wr_addr`.
  - 10 (RD_ADDR): latch `rd_addr`.
  - 01 (WR_DATA): load the pending slot with {we=1, addr=wr_addr, data=payload}.
  - 11 (RD_DATA): load the pending slot with {we=0, addr=rd_addr}; the payload is ignored.
- Pending slot (1 deep) stores its own address. A later address-latch command does not alter an access already pending.
- Slot full and a new 01/11 arrives without the slot being granted in the same cycle: the new access is dropped, `spi_overrun` pulses, and the slot is unchanged.
- Slot granted in the same cycle as a new 01/11 arrives: the slot reloads with the new access and there is no overrun.
- FSM states:
  - IDLE: if any request is present, grant one and drive the RAM that cycle. A write stays in IDLE. A read goes to RD_WAIT.
  - RD_WAIT: no grants. Capture `ram_rdata` into `spi_tx_data` or `host_rdata` according to the registered owner, then return to IDLE.
- Arbitration is two-way round-robin using `last_gnt` (SPI/HOST):
  - Both requesting: grant the one not equal to `last_gnt`.
  - Only one requesting: grant it.
  - `last_gnt` updates on every grant.
- `host_gnt` is asserted only in IDLE. The host must keep `host_req` and its fields stable until granted.
- Reset values: all outputs 0; `wr_addr`/`rd_addr` 0; slot empty; state IDLE; `last_gnt` = HOST, so SPI wins the first tie.
- Reset asserted mid-operation: the pending access and any in-flight read are discarded, and no strobe is issued after reset.

## Timing
- Cycle 0 is the cycle `spi_rx_valid` is high.
- SPI write: slot visible in cycle 1; `ram_en`=`ram_we`=1 in cycle 1 if idle and it wins arbitration.
- SPI read: `ram_en` in cycle 1, RD_WAIT in cycle 2, `spi_tx_valid` high in cycle 3 only.
- Host access: `host_gnt` and RAM drive in the same cycle (cycle g). Read: `host_rvalid` high in cycle g+2.
- Worst-case SPI grant delay: 3 cycles (host read plus RD_WAIT). This is well inside the minimum 10-clk spacing of SPI frames, so overrun is reachable only by forced stimulus.
- Back-to-back writes: one grant per cycle. Reads: at most one grant every 2 cycles.

## Structure
- Package `spi_shared`:
  - `spi_cmd_e` {CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11}.
  - `arb_state_e` {ARB_IDLE, ARB_RD_WAIT}.
  - `requester_e` {REQ_SPI, REQ_HOST}.
  - `pend_req_t` struct {we, addr, data}.
- Sub-module `rr_arb2`: two-requester round-robin with `last_gnt` register and an enable input (tied to state==IDLE). Grant output is one-hot and combinational.

## Test plan
- SPI 00 with payload 0x1A, then 01 with 0x5C: one RAM write addr 0x1A data 0x5C, 1 cycle after the second `rx_valid`; no tx strobe.
- SPI 10/0x1A then 11: `ram_en`, `ram_we`=0, addr 0x1A; `spi_tx_data`=0x5C with `spi_tx_valid` exactly 3 cycles after the 11 strobe.
- Host read addr 0x20 and SPI write both pending in the same cycle just after reset: SPI granted first; host granted next cycle; `host_rvalid` 2 cycles after `host_gnt`.
- Continuous `host_req` writes plus repeated SPI writes: grants alternate SPI/HOST; no request starved beyond 1 grant.
- Two 01 strobes 1 cycle apart while host holds the RAM in RD_WAIT: second is dropped, `spi_overrun` pulses once, first write completes.
- `rst` pulsed the cycle after an SPI 11 grant: no `spi_tx_valid`; all outputs 0; next 11 reads from `rd_addr`=0.
